dual_dac7611_tx: RTL and testbench

- Serial transmitter that drives two DAC7611 12-bit serial DACs from the audio synthesiser's parallel sample outputs.
- The two DACs share the serial clock and the active-low load strobe. Each DAC has its own data line.
- Sits between the voice mixer/filter output stage and the pads, i.e. the io_out[20:17] DAC pins.
- A valid/ready handshake accepts one stereo sample pair, shifts it out MSB-first, then pulses the load strobe.

---
 rtl/sid_dac_pkg.sv | 19 +
 rtl/dual_dac7611_tx_if.sv | 15 +
 rtl/dual_dac7611_tx_clk_div.sv | 30 +++
 rtl/dual_dac7611_tx.sv | 110 +++++++++++
 tb/tb_dual_dac7611_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_dac_pkg.sv
// Shared definitions for the dual DAC7611 serial transmitter: resolution,
// frame state encoding and the signed-to-offset-binary conversion.
package sid_dac_pkg;

   localparam int DAC_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      LOAD  = 2'd3
   } dac_state_e;

   // Flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
   function automatic logic [DAC_W-1:0] to_offset_binary(input logic [DAC_W-1:0] value);
      return {~value[DAC_W-1], value[DAC_W-2:0]};
   endfunction

endpackage

// File: rtl/dual_dac7611_tx_if.sv
// Valid/ready sample-pair channel feeding the dual DAC transmitter.
interface dual_dac7611_tx_if
   import sid_dac_pkg::*;
#(
   parameter int DATA_W = DAC_W
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] sample_a;
   logic [DATA_W-1:0] sample_b;

   modport master (output s_valid, output sample_a, output sample_b, input s_ready);
   modport slave  (input s_valid, input sample_a, input sample_b, output s_ready);

endinterface

// File: rtl/dual_dac7611_tx_clk_div.sv
// Half-period counter for the DAC serial clock; phase_tick marks the last
// system cycle of each half period.
module dac_clk_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic phase_tick
);

   localparam logic [7:0] LAST = 8'(DIV - 1);

   logic [7:0] cnt;

   // Restart on a new frame so the first half period is always a full DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
      end
   end

   assign phase_tick = en && (cnt == LAST);

endmodule

// File: rtl/dual_dac7611_tx.sv
// Dual DAC7611 transmitter: accepts a stereo sample pair, shifts both words out
// MSB-first on a shared serial clock, then pulses the shared load strobe.
module dual_dac7611_tx
   import sid_dac_pkg::*;
#(
   parameter int DATA_W    = DAC_W,
   parameter int DIV       = 2,
   parameter int SIGNED_IN = 0
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   dual_dac7611_tx_if.slave     s,
   output logic                 dac_clk,
   output logic                 dac_dat_1,
   output logic                 dac_dat_2,
   output logic                 dac_le_n,
   output logic                 busy
);

   localparam int BCW = $clog2(DATA_W);

   dac_state_e        state;
   dac_state_e        state_nx;
   logic [DATA_W-1:0] sreg_a;
   logic [DATA_W-1:0] sreg_b;
   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;
   logic [BCW-1:0]    bit_cnt;
   logic              phase_hi;
   logic              accept;
   logic              phase_tick;

   assign s.s_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = s.s_valid && (state == IDLE);

   assign cap_a = (SIGNED_IN != 0) ? to_offset_binary(s.sample_a) : s.sample_a;
   assign cap_b = (SIGNED_IN != 0) ? to_offset_binary(s.sample_b) : s.sample_b;

   dac_clk_div #(.DIV(DIV)) u_clk_div (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .load       (accept),
      .en         (busy),
      .phase_tick (phase_tick)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A frame ends after the high phase of the last bit, then one GAP and one LOAD half period.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = SHIFT;
         SHIFT:   if (phase_tick && phase_hi && (bit_cnt == '0)) state_nx = GAP;
         GAP:     if (phase_tick) state_nx = LOAD;
         LOAD:    if (phase_tick) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Data only moves on the falling dac_clk edge, giving DIV cycles of setup and hold.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         dac_clk   <= 1'b1;
         dac_dat_1 <= 1'b0;
         dac_dat_2 <= 1'b0;
         dac_le_n  <= 1'b1;
         sreg_a    <= '0;
         sreg_b    <= '0;
         bit_cnt   <= '0;
         phase_hi  <= 1'b0;
      end else begin
         dac_le_n <= (state_nx != LOAD);
         if (accept) begin
            sreg_a    <= cap_a;
            sreg_b    <= cap_b;
            dac_dat_1 <= cap_a[DATA_W-1];
            dac_dat_2 <= cap_b[DATA_W-1];
            dac_clk   <= 1'b0;
            phase_hi  <= 1'b0;
            bit_cnt   <= BCW'(DATA_W - 1);
         end else if ((state == SHIFT) && phase_tick) begin
            if (!phase_hi) begin
               dac_clk  <= 1'b1;
               phase_hi <= 1'b1;
            end else if (bit_cnt == '0) begin
               dac_dat_1 <= 1'b0;
               dac_dat_2 <= 1'b0;
               phase_hi  <= 1'b0;
            end else begin
               bit_cnt   <= bit_cnt - 1'b1;
               phase_hi  <= 1'b0;
               dac_clk   <= 1'b0;
               sreg_a    <= sreg_a << 1;
               sreg_b    <= sreg_b << 1;
               dac_dat_1 <= sreg_a[DATA_W-2];
               dac_dat_2 <= sreg_b[DATA_W-2];
            end
         end
      end
   end

endmodule

// File: tb/tb_dual_dac7611_tx.sv
// Directed bench for dual_dac7611_tx: three instances (DIV=2 unsigned, DIV=2
// signed, DIV=1) each watched by a DAC7611 shift/latch model.
module tb_dual_dac7611_tx;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;

   always #5 wb_clk_i = ~wb_clk_i;

   dual_dac7611_tx_if #(.DATA_W(12)) if0 ();
   dual_dac7611_tx_if #(.DATA_W(12)) if1 ();
   dual_dac7611_tx_if #(.DATA_W(12)) if2 ();

   logic [2:0] dclk, dd1, dd2, dlen, dbusy, drdy;

   assign drdy = {if2.s_ready, if1.s_ready, if0.s_ready};

   dual_dac7611_tx #(.DATA_W(12), .DIV(2), .SIGNED_IN(0)) u_main (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .s(if0),
      .dac_clk(dclk[0]), .dac_dat_1(dd1[0]), .dac_dat_2(dd2[0]), .dac_le_n(dlen[0]), .busy(dbusy[0]));

   dual_dac7611_tx #(.DATA_W(12), .DIV(2), .SIGNED_IN(1)) u_signed (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .s(if1),
      .dac_clk(dclk[1]), .dac_dat_1(dd1[1]), .dac_dat_2(dd2[1]), .dac_le_n(dlen[1]), .busy(dbusy[1]));

   dual_dac7611_tx #(.DATA_W(12), .DIV(1), .SIGNED_IN(0)) u_div1 (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .s(if2),
      .dac_clk(dclk[2]), .dac_dat_1(dd1[2]), .dac_dat_2(dd2[2]), .dac_le_n(dlen[2]), .busy(dbusy[2]));

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;

   int acc_cyc  [3] = '{default: 0};
   int acc_cnt  [3] = '{default: 0};
   int acc_hist [16] = '{default: 0};

   // Accept bookkeeping at the active edge; cycle k of a frame sees cyc = accept + k.
   always @(posedge wb_clk_i) begin
      cyc <= cyc + 1;
      if (if0.s_valid && drdy[0]) begin
         acc_cyc[0] <= cyc;
         acc_cnt[0] <= acc_cnt[0] + 1;
         if (acc_cnt[0] < 16) acc_hist[acc_cnt[0]] <= cyc;
      end
      if (if1.s_valid && drdy[1]) begin
         acc_cyc[1] <= cyc;
         acc_cnt[1] <= acc_cnt[1] + 1;
      end
      if (if2.s_valid && drdy[2]) begin
         acc_cyc[2] <= cyc;
         acc_cnt[2] <= acc_cnt[2] + 1;
      end
   end

   logic [11:0] sh_a [3] = '{default: '0};
   logic [11:0] sh_b [3] = '{default: '0};
   logic [11:0] lat_a [3] = '{default: '0};
   logic [11:0] lat_b [3] = '{default: '0};
   logic [11:0] hist_a [16] = '{default: '0};
   logic [11:0] hist_b [16] = '{default: '0};
   int rise_cnt [3] = '{default: 0};
   int le_cnt   [3] = '{default: 0};
   int le_first [3] = '{default: 0};
   int le_low   [3] = '{default: 0};
   int rdy_ret  [3] = '{default: 0};
   int setup_bad[3] = '{default: 0};
   int overlap  [3] = '{default: 0};
   logic [2:0] clk_prev = 3'b111;
   logic [2:0] len_prev = 3'b111;
   logic [2:0] rdy_prev = 3'b111;
   logic [2:0] d1_prev  = 3'b000;
   logic [2:0] d2_prev  = 3'b000;

   // DAC model: shift on each dac_clk rise (seen one half system cycle later), latch on the load strobe.
   always @(negedge wb_clk_i) begin
      for (int g = 0; g < 3; g++) begin
         if (dclk[g] && !clk_prev[g]) begin
            rise_cnt[g] <= rise_cnt[g] + 1;
            sh_a[g] <= {sh_a[g][10:0], dd1[g]};
            sh_b[g] <= {sh_b[g][10:0], dd2[g]};
            if ((dd1[g] !== d1_prev[g]) || (dd2[g] !== d2_prev[g])) setup_bad[g] <= setup_bad[g] + 1;
         end
         if (!dlen[g] && len_prev[g]) begin
            le_cnt[g]   <= le_cnt[g] + 1;
            le_first[g] <= cyc;
            lat_a[g]    <= sh_a[g];
            lat_b[g]    <= sh_b[g];
            if ((g == 0) && (le_cnt[0] < 16)) begin
               hist_a[le_cnt[0]] <= sh_a[0];
               hist_b[le_cnt[0]] <= sh_b[0];
            end
         end
         if (!dlen[g]) le_low[g] <= le_low[g] + 1;
         if (!dlen[g] && !dclk[g]) overlap[g] <= overlap[g] + 1;
         if (drdy[g] && !rdy_prev[g]) rdy_ret[g] <= cyc;
      end
      clk_prev <= dclk;
      len_prev <= dlen;
      rdy_prev <= drdy;
      d1_prev  <= dd1;
      d2_prev  <= dd2;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errs++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int g, input logic [11:0] a, input logic [11:0] b);
      @(negedge wb_clk_i);
      case (g)
         0: begin if0.sample_a = a; if0.sample_b = b; if0.s_valid = 1'b1; end
         1: begin if1.sample_a = a; if1.sample_b = b; if1.s_valid = 1'b1; end
         default: begin if2.sample_a = a; if2.sample_b = b; if2.s_valid = 1'b1; end
      endcase
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      if0.s_valid = 1'b0;
      if1.s_valid = 1'b0;
      if2.s_valid = 1'b0;
   endtask

   task automatic waitFrame(input int g, input int target, input int budget, input string tag);
      int t = 0;
      while (((le_cnt[g] < target) || !drdy[g]) && (t < budget)) begin
         @(negedge wb_clk_i);
         t++;
      end
      checkOutput(tag, 32'(t < budget), 32'd1);
      @(negedge wb_clk_i);
   endtask

   int r0, l0, low0, n0, t;

   initial begin
      if0.s_valid = 1'b0; if0.sample_a = '0; if0.sample_b = '0;
      if1.s_valid = 1'b0; if1.sample_a = '0; if1.sample_b = '0;
      if2.s_valid = 1'b0; if2.sample_a = '0; if2.sample_b = '0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      $display("[TB] reset and idle");
      r0 = rise_cnt[0];
      repeat (100) @(negedge wb_clk_i);
      checkOutput("idle_clk", 32'(dclk[0]), 32'd1);
      checkOutput("idle_le_n", 32'(dlen[0]), 32'd1);
      checkOutput("idle_data", {30'd0, dd2[0], dd1[0]}, 32'd0);
      checkOutput("idle_ready", 32'(drdy), 32'd7);
      checkOutput("idle_busy", 32'(dbusy), 32'd0);
      checkOutput("idle_edges", 32'(rise_cnt[0] - r0), 32'd0);

      $display("[TB] single frame A5C/3F1, DIV=2");
      r0 = rise_cnt[0]; l0 = le_cnt[0]; low0 = le_low[0];
      applyStimulus(0, 12'hA5C, 12'h3F1);
      checkOutput("c1_clk_low", 32'(dclk[0]), 32'd0);
      checkOutput("c1_msb", {30'd0, dd2[0], dd1[0]}, 32'd1);
      checkOutput("c1_busy", 32'(dbusy[0]), 32'd1);
      checkOutput("c1_ready", 32'(drdy[0]), 32'd0);
      waitFrame(0, l0 + 1, 200, "frame1_timeout");
      checkOutput("f1_lat_a", 32'(lat_a[0]), 32'hA5C);
      checkOutput("f1_lat_b", 32'(lat_b[0]), 32'h3F1);
      checkOutput("f1_edges", 32'(rise_cnt[0] - r0), 32'd12);
      checkOutput("f1_le_start", 32'(le_first[0] - acc_cyc[0]), 32'd51);
      checkOutput("f1_le_width", 32'(le_low[0] - low0), 32'd2);
      checkOutput("f1_ready_back", 32'(rdy_ret[0] - acc_cyc[0]), 32'd53);

      $display("[TB] signed frame 800/7FF");
      applyStimulus(1, 12'h800, 12'h7FF);
      waitFrame(1, 1, 200, "signed_timeout");
      checkOutput("sg_lat_a", 32'(lat_a[1]), 32'h000);
      checkOutput("sg_lat_b", 32'(lat_b[1]), 32'hFFF);

      $display("[TB] back-to-back with valid held");
      n0 = acc_cnt[0]; l0 = le_cnt[0];
      @(negedge wb_clk_i);
      if0.sample_a = 12'h001; if0.sample_b = 12'h001; if0.s_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while ((acc_cnt[0] < n0 + k + 1) && (t < 200)) begin
            @(negedge wb_clk_i);
            t++;
         end
         checkOutput("b2b_accept_timeout", 32'(t < 200), 32'd1);
         if0.sample_a = 12'hFFF; if0.sample_b = 12'hFFF;
         repeat (10) @(negedge wb_clk_i);
         if (k < 3) begin
            if0.sample_a = 12'(1 << (k + 1));
            if0.sample_b = 12'(1 << (k + 1));
         end else begin
            if0.s_valid = 1'b0;
         end
      end
      waitFrame(0, l0 + 4, 400, "b2b_timeout");
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("b2b_lat_a%0d", i), 32'(hist_a[l0 + i]), 32'(1 << i));
         checkOutput($sformatf("b2b_lat_b%0d", i), 32'(hist_b[l0 + i]), 32'(1 << i));
      end
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("b2b_period%0d", i), 32'(acc_hist[n0 + i + 1] - acc_hist[n0 + i]), 32'd53);
      end

      $display("[TB] reset abort during bit 5 of 555");
      l0 = le_cnt[0];
      applyStimulus(0, 12'h555, 12'h555);
      repeat (21) @(negedge wb_clk_i);
      checkOutput("abort_bit5", {30'd0, dd2[0], dd1[0]}, 32'd3);
      checkOutput("abort_clk_low", 32'(dclk[0]), 32'd0);
      wb_rst_i = 1'b1;
      #1;
      checkOutput("abort_clk", 32'(dclk[0]), 32'd1);
      checkOutput("abort_data", {30'd0, dd2[0], dd1[0]}, 32'd0);
      checkOutput("abort_le_n", 32'(dlen[0]), 32'd1);
      checkOutput("abort_ready", 32'(drdy[0]), 32'd1);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (60) @(negedge wb_clk_i);
      checkOutput("abort_no_load", 32'(le_cnt[0] - l0), 32'd0);
      checkOutput("abort_lat_kept", 32'(lat_a[0]), 32'h008);
      applyStimulus(0, 12'h123, 12'h123);
      waitFrame(0, l0 + 1, 200, "post_abort_timeout");
      checkOutput("post_abort_a", 32'(lat_a[0]), 32'h123);
      checkOutput("post_abort_b", 32'(lat_b[0]), 32'h123);
      checkOutput("main_le_clk_overlap", 32'(overlap[0]), 32'd0);

      $display("[TB] DIV=1 frame FFF/000");
      r0 = rise_cnt[2]; l0 = le_cnt[2]; low0 = le_low[2];
      applyStimulus(2, 12'hFFF, 12'h000);
      waitFrame(2, l0 + 1, 100, "div1_timeout");
      checkOutput("d1_lat_a", 32'(lat_a[2]), 32'hFFF);
      checkOutput("d1_lat_b", 32'(lat_b[2]), 32'h000);
      checkOutput("d1_edges", 32'(rise_cnt[2] - r0), 32'd12);
      checkOutput("d1_le_start", 32'(le_first[2] - acc_cyc[2]), 32'd26);
      checkOutput("d1_le_width", 32'(le_low[2] - low0), 32'd1);
      checkOutput("d1_ready_back", 32'(rdy_ret[2] - acc_cyc[2]), 32'd27);
      checkOutput("d1_setup", 32'(setup_bad[2]), 32'd0);
      checkOutput("d1_le_clk_overlap", 32'(overlap[2]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
